// File: rtl/playback_pkg.sv
// rtl/playback_pkg.sv - shared state encoding for the playback scheduler
package playback_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_PAUSE = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/pow2_tick_gen.sv
// rtl/pow2_tick_gen.sv - gated power-of-two prescaler emitting one tick per 2^Power enabled cycles
module pow2_tick_gen #(
    parameter int Power = 4
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [Power-1:0] count_q;
    logic [Power-1:0] count_d;

    // clear wins over enable; the all-ones count wraps to zero by natural overflow
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // prescaler register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = en && (count_q == {Power{1'b1}});

endmodule

// File: rtl/playback_scheduler.sv
// rtl/playback_scheduler.sv - frame playback FSM; define LOOP_PLAYBACK_EN to loop playback until stop
module playback_scheduler
    import playback_pkg::*;
#(
    parameter int Power      = 4,
    parameter int FrameDiv   = 3,
    parameter int FrameCount = 6572,
    parameter int FrameWidth = 13
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
    output logic                  busy,
    output logic                  paused,
    output logic                  frame_tick,
    output logic [FrameWidth-1:0] frame_index,
    output logic                  done
);

    localparam int SubW = (FrameDiv > 1) ? $clog2(FrameDiv) : 1;
    localparam logic [SubW-1:0]       SUB_LAST = SubW'(FrameDiv - 1);
    localparam logic [FrameWidth-1:0] IDX_LAST = FrameWidth'(FrameCount - 1);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [SubW-1:0]       subdiv_q, subdiv_d;
    logic [FrameWidth-1:0] frame_index_q, frame_index_d;
    logic                  busy_q, busy_d;
    logic                  paused_q, paused_d;
    logic                  frame_tick_q, frame_tick_d;
    logic                  done_q, done_d;

    logic run_active;
    logic presc_en;
    logic presc_clr;
    logic tick;
    logic boundary;

    // timing only advances in RUN/PAUSE on cycles where neither stop nor pause is sampled
    assign run_active = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign presc_en   = run_active && !stop && !pause;
    assign presc_clr  = (state_q == ST_IDLE) || stop;
    assign boundary   = tick && (subdiv_q == SUB_LAST);

    pow2_tick_gen #(
        .Power(Power)
    ) u_tick_gen (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .en    (presc_en),
        .tick  (tick)
    );

    // ticks-per-frame counter, wrapping on each frame boundary
    always_comb begin
        subdiv_d = subdiv_q;
        if (presc_clr) begin
            subdiv_d = '0;
        end else if (tick) begin
            subdiv_d = boundary ? '0 : subdiv_q + 1'b1;
        end
    end

    // control FSM with stop > pause > start priority, frame indexing and output pulses
    always_comb begin
        state_d       = state_q;
        frame_index_d = frame_index_q;
        frame_tick_d  = 1'b0;
        done_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!stop && !pause && start) begin
                    state_d       = ST_RUN;
                    frame_index_d = '0;
                    frame_tick_d  = 1'b1;
                end
            end
            ST_RUN, ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                    if (boundary) begin
                        if (frame_index_q < IDX_LAST) begin
                            frame_index_d = frame_index_q + 1'b1;
                            frame_tick_d  = 1'b1;
                        end else begin
`ifdef LOOP_PLAYBACK_EN
                            frame_index_d = '0;
                            frame_tick_d  = 1'b1;
                            done_d        = 1'b1;
`else
                            state_d       = ST_DONE;
                            done_d        = 1'b1;
`endif
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d   = (state_d == ST_RUN) || (state_d == ST_PAUSE);
        paused_d = (state_d == ST_PAUSE);
    end

    // state and registered outputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            subdiv_q      <= '0;
            frame_index_q <= '0;
            busy_q        <= 1'b0;
            paused_q      <= 1'b0;
            frame_tick_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            subdiv_q      <= subdiv_d;
            frame_index_q <= frame_index_d;
            busy_q        <= busy_d;
            paused_q      <= paused_d;
            frame_tick_q  <= frame_tick_d;
            done_q        <= done_d;
        end
    end

    assign busy        = busy_q;
    assign paused      = paused_q;
    assign frame_tick  = frame_tick_q;
    assign frame_index = frame_index_q;
    assign done        = done_q;

endmodule

// File: tb/tb_playback_scheduler.sv
// tb/tb_playback_scheduler.sv - scoreboard bench for playback_scheduler
module tb_playback_scheduler;

    localparam int P      = 2;
    localparam int FD     = 2;
    localparam int FC     = 3;
    localparam int FW     = 2;
    localparam int PERIOD = FD * (1 << P);
`ifdef LOOP_PLAYBACK_EN
    localparam int LOOP = 1;
`else
    localparam int LOOP = 0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic          pause  = 1'b0;
    logic          stop   = 1'b0;
    logic          busy;
    logic          paused;
    logic          frame_tick;
    logic [FW-1:0] frame_index;
    logic          done;

    int cyc          = 0;
    int tests_run    = 0;
    int tests_failed = 0;
    int tick_count   = 0;
    int t0;

    typedef struct {
        int cyc;
        int idx;
        int tick;
        int done;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;

    playback_scheduler #(
        .Power     (P),
        .FrameDiv  (FD),
        .FrameCount(FC),
        .FrameWidth(FW)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .busy       (busy),
        .paused     (paused),
        .frame_tick (frame_tick),
        .frame_index(frame_index),
        .done       (done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk_in);
    endtask

    task automatic push_ev(input int c, input int idx, input int tk, input int dn);
        ev_t e;
        e.cyc  = c;
        e.idx  = idx;
        e.tick = tk;
        e.done = dn;
        exp_q.push_back(e);
    endtask

    // full playback; shift = cycles of pause inserted before frame 1
    task automatic push_run(input int s);
        push_ev(t0, 0, 1, 0);
        push_ev(t0 + PERIOD + s, 1, 1, 0);
        push_ev(t0 + 2 * PERIOD + s, 2, 1, 0);
        push_ev(t0 + 3 * PERIOD + s, (LOOP != 0) ? 0 : FC - 1, LOOP, 1);
    endtask

    // start is raised at a falling edge; the following rising edge is t0
    task automatic begin_run();
        tick_count = 0;
        t0 = cyc + 1;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic finish_run(input int s);
        wait_until(t0 + 3 * PERIOD + 1 + s);
        check("busy_after_last", busy, LOOP);
        stop = 1'b1;
        @(negedge clk_in);
        stop = 1'b0;
        check("busy_after_stop", busy, 0);
        check("final_index", frame_index, (LOOP != 0) ? 0 : FC - 1);
        check("tick_count", tick_count, 3 + LOOP);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // scoreboard: every frame_tick/done pulse must match the next expected event
    always @(negedge clk_in) begin
        if (rst_n && (frame_tick || done)) begin
            if (frame_tick) tick_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_event", cyc, 32'hFFFF_FFFF);
            end else begin
                ev = exp_q.pop_front();
                check("ev_cycle", cyc, ev.cyc);
                check("ev_index", frame_index, ev.idx);
                check("ev_tick", frame_tick, ev.tick);
                check("ev_done", done, ev.done);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk_in);
        check("rst_busy", busy, 0);
        check("rst_paused", paused, 0);
        check("rst_tick", frame_tick, 0);
        check("rst_index", frame_index, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk_in);

        // plain playback
        begin_run();
        push_run(0);
        check("busy_run", busy, 1);
        finish_run(0);

        // pause for 5 cycles mid-frame
        begin_run();
        push_run(5);
        wait_until(t0 + 2);
        pause = 1'b1;
        wait_until(t0 + 3);
        check("paused_mid", paused, 1);
        check("busy_paused", busy, 1);
        wait_until(t0 + 7);
        pause = 1'b0;
        wait_until(t0 + 8);
        check("resumed", paused, 0);
        finish_run(5);

        // pause exactly on the boundary edge defers the tick by one cycle
        begin_run();
        push_run(1);
        wait_until(t0 + PERIOD - 1);
        pause = 1'b1;
        wait_until(t0 + PERIOD);
        check("paused_boundary", paused, 1);
        check("deferred_tick", frame_tick, 0);
        pause = 1'b0;
        finish_run(1);

        // stop mid-playback: no done, index held
        begin_run();
        push_ev(t0, 0, 1, 0);
        push_ev(t0 + PERIOD, 1, 1, 0);
        wait_until(t0 + 10);
        stop = 1'b1;
        wait_until(t0 + 11);
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_index", frame_index, 1);
        check("stop_done", done, 0);
        wait_until(t0 + 40);
        check("stop_ticks", tick_count, 2);
        check("stop_queue", exp_q.size(), 0);
        stop  = 1'b1;
        start = 1'b1;
        @(negedge clk_in);
        stop  = 1'b0;
        start = 1'b0;
        check("stop_start_busy", busy, 0);
        check("stop_start_tick", frame_tick, 0);
        begin_run();
        push_run(0);
        finish_run(0);

        // asynchronous reset between edges
        begin_run();
        push_ev(t0, 0, 1, 0);
        push_ev(t0 + PERIOD, 1, 1, 0);
        wait_until(t0 + 10);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_paused", paused, 0);
        check("arst_tick", frame_tick, 0);
        check("arst_index", frame_index, 0);
        check("arst_done", done, 0);
        check("arst_queue", exp_q.size(), 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        begin_run();
        push_run(0);
        finish_run(0);

        repeat (4) @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
